// File: rtl/kappa3_pkg.sv
// rtl/kappa3_pkg.sv - shared phase, opcode and access-size definitions for KAPPA3
package kappa3_pkg;

  // Phase codes double as the one-hot cstate value; HALT is all zeros.
  typedef enum logic [3:0] {
    ST_HALT = 4'b0000,
    ST_IF   = 4'b0001,
    ST_DE   = 4'b0010,
    ST_EX   = 4'b0100,
    ST_WB   = 4'b1000
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;
  localparam logic [2:0] F3_D = 3'b011;

endpackage

// File: rtl/kappa3_wrbits.sv
// rtl/kappa3_wrbits.sv - byte-enable and alignment check for a memory access
module kappa3_wrbits
  import kappa3_pkg::*;
#(
  parameter  int NBYTE = 4,
  localparam int AW    = $clog2(NBYTE)
) (
  input  logic [2:0]       i_funct3,
  input  logic [AW-1:0]    i_addr_lo,
  output logic [NBYTE-1:0] o_wrbits,
  output logic             o_misal
);

  always_comb begin
    o_wrbits = '1;
    o_misal  = 1'b0;
    case (i_funct3)
      F3_B: o_wrbits = NBYTE'(1) << i_addr_lo;
      F3_H: begin
        o_wrbits = NBYTE'(3) << i_addr_lo;
        o_misal  = i_addr_lo[0];
      end
      F3_W: begin
        o_wrbits = NBYTE'(15) << i_addr_lo;
        o_misal  = |i_addr_lo[1:0];
      end
      // Doubleword only exists on a 64-bit datapath; otherwise it is a full-width access.
      F3_D: if (NBYTE == 8) o_misal = |i_addr_lo;
      default: ;
    endcase
  end

endmodule

// File: rtl/kappa3_seq_ctrl.sv
// rtl/kappa3_seq_ctrl.sv - run/step/stop phase sequencer with memory wait and bus-error handling
module kappa3_seq_ctrl
  import kappa3_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int WAIT_MAX = 15,
  localparam int NBYTE    = XLEN / 8,
  localparam int AW       = $clog2(NBYTE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             stop,
  input  logic [31:0]      ir,
  input  logic [XLEN-1:0]  addr,
  input  logic             mem_ready,
  output logic [3:0]       cstate,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBYTE-1:0] mem_wrbits,
  output logic             ir_ld,
  output logic             busy,
  output logic             bus_err,
  output logic [31:0]      instr_cnt
);

  state_e           r_state, w_next;
  logic             r_step, r_stop, r_bus_err;
  logic [7:0]       r_wait;
  logic [31:0]      r_cnt;
  logic             w_is_load, w_is_store, w_memop, w_misal;
  logic [NBYTE-1:0] w_bits;
  logic             w_wait, w_timeout, w_wb_err, w_wb_done, w_halt_req;
  logic             w_unused_bits;

  assign w_unused_bits = &{1'b0, addr[XLEN-1:AW], ir[31:15], ir[11:7]};

  kappa3_wrbits #(.NBYTE(NBYTE)) u_wrbits (
    .i_funct3  (ir[14:12]),
    .i_addr_lo (addr[AW-1:0]),
    .o_wrbits  (w_bits),
    .o_misal   (w_misal)
  );

  assign w_is_load  = (ir[6:0] == OP_LOAD);
  assign w_is_store = (ir[6:0] == OP_STORE);
  assign w_memop    = w_is_load | w_is_store;

  assign w_wait     = mem_req & ~mem_ready;
  assign w_timeout  = w_wait & (r_wait == 8'(WAIT_MAX - 1));
  assign w_wb_err   = (r_state == ST_WB) & w_memop & w_misal;
  assign w_wb_done  = (r_state == ST_WB) & ~w_wb_err & (~w_memop | mem_ready);
  // A stop arriving in the very cycle WB completes still counts as pending.
  assign w_halt_req = r_step | r_stop | stop | ~run;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_HALT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HALT: if (run | step) w_next = ST_IF;
      ST_IF: begin
        if (mem_ready)      w_next = ST_DE;
        else if (w_timeout) w_next = ST_HALT;
      end
      ST_DE: w_next = ST_EX;
      ST_EX: w_next = ST_WB;
      ST_WB: begin
        if (w_wb_err | w_timeout) w_next = ST_HALT;
        else if (w_wb_done)       w_next = w_halt_req ? ST_HALT : ST_IF;
      end
      default: w_next = ST_HALT;
    endcase
  end

  always_comb begin
    mem_req    = (r_state == ST_IF) | ((r_state == ST_WB) & w_memop & ~w_misal);
    mem_we     = (r_state == ST_WB) & w_is_store & ~w_misal;
    mem_wrbits = mem_we ? w_bits : '0;
    ir_ld      = (r_state == ST_IF) & mem_ready;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step    <= 1'b0;
      r_stop    <= 1'b0;
      r_bus_err <= 1'b0;
      r_wait    <= '0;
      r_cnt     <= '0;
    end else begin
      r_wait <= w_wait ? r_wait + 8'd1 : 8'd0;
      if (r_state == ST_HALT) begin
        if (run | step) begin
          r_bus_err <= 1'b0;
          r_step    <= step;
        end
      end else begin
        if (stop) r_stop <= 1'b1;
        if (w_next == ST_HALT) begin
          r_step <= 1'b0;
          r_stop <= 1'b0;
        end
        if (w_timeout | w_wb_err) r_bus_err <= 1'b1;
        if (w_wb_done)            r_cnt     <= r_cnt + 32'd1;
      end
    end
  end

  assign cstate    = r_state;
  assign busy      = (r_state != ST_HALT);
  assign bus_err   = r_bus_err;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_kappa3_seq_ctrl.sv
// tb/tb_kappa3_seq_ctrl.sv - directed self-checking bench for kappa3_seq_ctrl (XLEN=64)
module tb_kappa3_seq_ctrl;

  localparam int XLEN  = 64;
  localparam int NBYTE = XLEN / 8;

  localparam logic [31:0] I_ADDI = 32'h0010_0093;
  localparam logic [31:0] I_SB   = 32'h0000_0023;
  localparam logic [31:0] I_SH   = 32'h0000_1023;
  localparam logic [31:0] I_SW   = 32'h0000_2023;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             run = 1'b0, step = 1'b0, stop = 1'b0, mem_ready = 1'b1;
  logic [31:0]      ir = I_ADDI;
  logic [XLEN-1:0]  addr = '0;
  logic [3:0]       cstate;
  logic             mem_req, mem_we, ir_ld, busy, bus_err;
  logic [NBYTE-1:0] mem_wrbits;
  logic [31:0]      instr_cnt;
  logic [3:0]       one_hot;

  int n_checks = 0;
  int n_fails  = 0;

  kappa3_seq_ctrl #(.XLEN(XLEN), .WAIT_MAX(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .stop       (stop),
    .ir         (ir),
    .addr       (addr),
    .mem_ready  (mem_ready),
    .cstate     (cstate),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_wrbits (mem_wrbits),
    .ir_ld      (ir_ld),
    .busy       (busy),
    .bus_err    (bus_err),
    .instr_cnt  (instr_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic to_wb();
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  initial begin
    #12;
    chk("rst_cstate", cstate, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_cnt", instr_cnt, 32'd0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_ir_ld", ir_ld, 1'b0);
    chk("rst_wrbits", mem_wrbits, 8'h00);
    reset = 1'b1;

    // free run, zero-wait memory
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      one_hot = 4'b0001 << (i % 4);
      chk("run_cstate", cstate, one_hot);
      if (i == 0) chk("run_ir_ld", ir_ld, 1'b1);
    end
    cyc();
    chk("run_cnt3", instr_cnt, 32'd3);
    chk("run_if_again", cstate, 4'b0001);

    // stop pulse during DE
    cyc();
    chk("stop_de", cstate, 4'b0010);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    chk("stop_wb", cstate, 4'b1000);
    cyc();
    chk("stop_halt_cstate", cstate, 4'b0000);
    chk("stop_halt_busy", busy, 1'b0);
    chk("stop_cnt", instr_cnt, 32'd4);
    run = 1'b0;

    // single step with two IF wait cycles
    step = 1'b1;
    mem_ready = 1'b0;
    cyc();
    step = 1'b0;
    #1;
    chk("step_if", cstate, 4'b0001);
    chk("step_ir_ld_wait", ir_ld, 1'b0);
    chk("step_mem_req", mem_req, 1'b1);
    cyc();
    chk("step_if_w1", cstate, 4'b0001);
    cyc();
    chk("step_if_w2", cstate, 4'b0001);
    mem_ready = 1'b1;
    #1;
    chk("step_ir_ld", ir_ld, 1'b1);
    cyc();
    chk("step_de", cstate, 4'b0010);
    cyc();
    cyc();
    cyc();
    chk("step_halt", cstate, 4'b0000);
    chk("step_cnt", instr_cnt, 32'd5);

    // SH at 0x6 with one store wait cycle
    ir = I_SH;
    addr = 64'h6;
    to_wb();
    mem_ready = 1'b0;
    #1;
    chk("sh_cstate", cstate, 4'b1000);
    chk("sh_mem_req", mem_req, 1'b1);
    chk("sh_mem_we", mem_we, 1'b1);
    chk("sh_wrbits", mem_wrbits, 8'hC0);
    cyc();
    chk("sh_wait_wb", cstate, 4'b1000);
    mem_ready = 1'b1;
    cyc();
    chk("sh_halt", cstate, 4'b0000);
    chk("sh_cnt", instr_cnt, 32'd6);

    // SB at 0x3
    ir = I_SB;
    addr = 64'h3;
    to_wb();
    #1;
    chk("sb_wrbits", mem_wrbits, 8'h08);
    cyc();
    chk("sb_cnt", instr_cnt, 32'd7);

    // misaligned SH at 0x5
    ir = I_SH;
    addr = 64'h5;
    to_wb();
    #1;
    chk("mis_mem_req", mem_req, 1'b0);
    chk("mis_wrbits", mem_wrbits, 8'h00);
    cyc();
    chk("mis_halt", cstate, 4'b0000);
    chk("mis_bus_err", bus_err, 1'b1);
    chk("mis_cnt", instr_cnt, 32'd7);

    // fetch timeout after WAIT_MAX wait cycles
    ir = I_ADDI;
    addr = '0;
    mem_ready = 1'b0;
    run = 1'b1;
    cyc();
    chk("to_if", cstate, 4'b0001);
    chk("to_err_cleared", bus_err, 1'b0);
    for (int i = 1; i < 15; i++) cyc();
    chk("to_still_if", cstate, 4'b0001);
    cyc();
    chk("to_halt", cstate, 4'b0000);
    chk("to_bus_err", bus_err, 1'b1);
    chk("to_cnt", instr_cnt, 32'd7);
    run = 1'b0;
    mem_ready = 1'b1;
    cyc();
    run = 1'b1;
    cyc();
    chk("rerun_bus_err", bus_err, 1'b0);
    chk("rerun_if", cstate, 4'b0001);
    run = 1'b0;

    // reset during a store wait in WB
    ir = I_SW;
    addr = 64'h8;
    cyc();
    cyc();
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("sw_mem_req", mem_req, 1'b1);
    chk("sw_wrbits", mem_wrbits, 8'h0F);
    cyc();
    chk("sw_wait_wb", cstate, 4'b1000);
    reset = 1'b0;
    #1;
    chk("ar_cstate", cstate, 4'b0000);
    chk("ar_busy", busy, 1'b0);
    chk("ar_bus_err", bus_err, 1'b0);
    chk("ar_mem_req", mem_req, 1'b0);
    chk("ar_mem_we", mem_we, 1'b0);
    chk("ar_wrbits", mem_wrbits, 8'h00);
    chk("ar_ir_ld", ir_ld, 1'b0);
    chk("ar_cnt", instr_cnt, 32'd0);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/kappa3_seq_ctrl.md
# kappa3_seq_ctrl

Parametrised phase sequencer for the KAPPA3 core. It replaces the fixed four-phase generator with a state machine that adds run/step/stop control, variable-latency memory handshakes and bus-error timeout. It also provides XLEN-generic store byte-enables and a retired-instruction counter. The combinational controller is unchanged: it consumes this block's `cstate` output as before.

## Interface
Parameters:
- `XLEN`, 32: datapath width; legal values 32 or 64. `NBYTE = XLEN/8`.
- `WAIT_MAX`, 15: maximum wait cycles per memory access before `bus_err`; range 1..255.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; start or continue free-running execution.
- `step`  in  1  one-cycle pulse; execute exactly one instruction.
- `stop`  in  1  one-cycle pulse; halt after the current instruction completes.
- `ir`  in  32  instruction register value (opcode and funct3 used).
- `addr`  in  XLEN  data memory address (low bits used).
- `mem_ready`  in  1  memory completes the current access this cycle.
- `cstate`  out  4  one-hot phase: IF=0001, DE=0010, EX=0100, WB=1000; 0000 while halted.
- `mem_req`  out  1  memory access pending.
- `mem_we`  out  1  pending access is a store.
- `mem_wrbits`  out  NBYTE  store byte enables.
- `ir_ld`  out  1  load IR (fetch completes).
- `busy`  out  1  not halted.
- `bus_err`  out  1  sticky: timeout or misaligned access.
- `instr_cnt`  out  32  retired instructions; wraps modulo 2^32.

## Operation
- States: HALT, IF, DE, EX, WB.
- HALT: `cstate`=0, `busy`=0.
  - `run`=1 or `step`=1 → IF. Entering IF from HALT clears `bus_err`.
  - `step` latches step mode.
- IF:
  - `mem_req`=1, `mem_we`=0.
  - Stays in IF until `mem_ready`. In the ready cycle `ir_ld`=1, then → DE.
- DE → EX → WB, one cycle each, unconditional.
- WB, load (opcode 0000011) or store (0100011):
  - `mem_req`=1; `mem_we`=1 for a store.
  - Waits for `mem_ready`, exactly as IF does.
- WB, all other opcodes: one cycle.
- WB completion (`mem_ready` seen, or the single cycle for non-memory ops):
  - `instr_cnt` += 1.
  - → HALT if step mode, `stop` pending, or `run`=0; otherwise → IF.
  - Step mode and pending `stop` are cleared on this transition.
- `stop` pulse in any non-HALT state is latched until the next WB completion. `stop` in HALT is ignored.
- Wait counter:
  - Counts cycles with `mem_req`=1 and `mem_ready`=0; reset at each access start.
  - Reaching `WAIT_MAX` → `bus_err`=1, → HALT, no `ir_ld`, no count increment.
- `mem_wrbits` (stores only; all zeros otherwise):
  - funct3 000: SB, one bit at `addr[log2 NBYTE-1:0]`.
  - 001: SH, two bits; requires `addr[0]`=0.
  - 010: SW, four bits; requires `addr[1:0]`=0.
  - 011: SD, all bits; only when XLEN=64, requires `addr[2:0]`=0.
  - Any other funct3: all ones.
- Misaligned load or store (same alignment rules applied to the load funct3):
  - In the first WB cycle: no `mem_req`, `bus_err`=1, → HALT.

## Timing
- Reset values: state HALT; `cstate`=0; `mem_req`, `mem_we`, `ir_ld`, `busy`, `bus_err`=0; `mem_wrbits`=0; `instr_cnt`=0; step/stop latches cleared.
- `cstate`, `busy`, `bus_err`, `instr_cnt` are registered.
- `mem_req`, `mem_we`, `mem_wrbits`, `ir_ld` are combinational from state, `ir`, `addr` and `mem_ready`.
- With zero-wait memory (`mem_ready` tied high): 4 cycles per instruction, identical to the legacy phase generator.
- Each memory wait cycle adds exactly one cycle to that phase.
- `run` and `step` sampled together in HALT: step mode wins.
- Reset asserted mid-access: immediate return to HALT. The outstanding memory request is abandoned; memory must tolerate this.

## Structure
- Shared package `kappa3_pkg` holds:
  - Phase encodings IF/DE/EX/WB.
  - Opcode constants `OP_LOAD`, `OP_STORE`.
  - funct3 size codes.
- Sub-module `kappa3_wrbits`: combinational byte-enable and alignment-check generator, parametrised by `NBYTE`. It is reused by the future load-extend unit.

## Test plan
- Reset, then `run`=1 with `mem_ready`=1 and an ADDI in `ir` → `cstate` sequence 0001,0010,0100,1000 repeating; `instr_cnt`=3 after 12 cycles.
- `step` pulse, IF held for 2 wait cycles → IF lasts 3 cycles, single `ir_ld`, returns to `cstate`=0 with `instr_cnt`=1.
- XLEN=64, SH at `addr`=0x6 → `mem_wrbits`=0xC0, `mem_we`=1 in WB; SH at `addr`=0x5 → `bus_err`=1, HALT, no `mem_req`.
- `mem_ready` held low in IF with `WAIT_MAX`=15 → `bus_err`=1 after 15 wait cycles, `cstate`=0; a following `run` clears `bus_err`.
- `stop` pulse during DE while running → current instruction completes WB, then `cstate`=0, `busy`=0.
- Reset asserted during a store wait in WB → all outputs at reset values on the same edge; `instr_cnt`=0.
